seven_seg_capture_decoder: RTL

//  Receive-side counterpart of the hex-to-7-segment encoder. Monitors a multiplexed, active-low
//  7-segment display bus (segments + digit anodes), waits for each pattern to settle, then

---
 rtl/seven_seg_capture_decoder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/seven_seg_capture_decoder.sv
// seven_seg_capture_decoder
//   Watches a multiplexed active-low 7-segment bus, waits for each
//   {an_n, seg_n} pattern to settle for STABLE_CYCLES samples, then decodes the
//   glyph back to a hex nibble. Each capture updates a per-digit register file
//   (legal glyphs only) and is offered on a single-entry valid/ready stream.
//
// Ports
//   clk, rst_n     system clock, async active-low reset
//   seg_n          segment lines, active low, [0]=a .. [6]=g
//   an_n           digit enables, active low
//   out_ready      consumer accepts the stream word this cycle
//   clr_overflow   clears the sticky overflow flag
//   out_valid      stream word valid
//   out_digit      captured digit index
//   out_nibble     decoded value (0 for an illegal glyph)
//   out_err        captured pattern was not a legal hex glyph
//   digits         last legal value per digit, digit i at [4i+3:4i]
//   digit_valid    digit i has seen at least one legal capture
//   overflow       sticky: a capture was dropped while the stream was stalled
module seven_seg_capture_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8,
  localparam int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic                    out_ready,
  input  logic                    clr_overflow,
  output logic                    out_valid,
  output logic [IDX_W-1:0]        out_digit,
  output logic [3:0]              out_nibble,
  output logic                    out_err,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    overflow
);

  localparam int W     = NUM_DIGITS + 7;
  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(STABLE_CYCLES - 1);

  logic [W-1:0]     live;
  logic [W-1:0]     smp;
  logic [CNT_W-1:0] cnt;
  logic             fired;
  logic             same;
  logic             one_low;
  logic             multi_low;
  logic [IDX_W-1:0] idx;
  logic [3:0]       nib;
  logic             legal;
  logic             capture;
  logic             load;
  logic             drop;

  assign live = {an_n, seg_n};
  assign same = (live == smp);

  // Locate the single driven digit; multi_low flags more than one low anode.
  always_comb begin
    one_low   = 1'b0;
    multi_low = 1'b0;
    idx       = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_n[i]) begin
        if (one_low) multi_low = 1'b1;
        one_low = 1'b1;
        idx     = IDX_W'(i);
      end
    end
  end

  always_comb begin
    nib   = 4'h0;
    legal = 1'b1;
    case (seg_n)
      7'h40: nib = 4'h0;
      7'h79: nib = 4'h1;
      7'h24: nib = 4'h2;
      7'h30: nib = 4'h3;
      7'h19: nib = 4'h4;
      7'h12: nib = 4'h5;
      7'h02: nib = 4'h6;
      7'h78: nib = 4'h7;
      7'h00: nib = 4'h8;
      7'h10: nib = 4'h9;
      7'h08: nib = 4'hA;
      7'h03: nib = 4'hB;
      7'h46: nib = 4'hC;
      7'h21: nib = 4'hD;
      7'h06: nib = 4'hE;
      7'h0E: nib = 4'hF;
      default: legal = 1'b0;
    endcase
  end

  // fired blocks a second capture within one stable period; cnt saturates.
  assign capture = same && (cnt == CNT_FIRE) && !fired && one_low && !multi_low;
  assign load    = capture && (!out_valid || out_ready);
  assign drop    = capture && out_valid && !out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp   <= '0;
      cnt   <= '0;
      fired <= 1'b0;
    end else begin
      smp <= live;
      if (!same) begin
        cnt   <= '0;
        fired <= 1'b0;
      end else begin
        if (cnt != CNT_MAX) cnt <= cnt + CNT_W'(1);
        if (capture) fired <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_digit  <= '0;
      out_nibble <= 4'h0;
      out_err    <= 1'b0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_digit  <= idx;
      out_nibble <= legal ? nib : 4'h0;
      out_err    <= !legal;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (clr_overflow) begin
      overflow <= 1'b0;
    end
  end

  // Register file updates even when the stream word is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits      <= '0;
      digit_valid <= '0;
    end else if (capture && legal) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (idx == IDX_W'(i)) begin
          digits[4*i +: 4] <= nib;
          digit_valid[i]   <= 1'b1;
        end
      end
    end
  end

endmodule
